fetch_queue_unit: RTL and testbench

//  Next-gen instruction fetch stage: PC generation plus a DEPTH-entry fetch queue.

---
 rtl/fetch_queue_unit.sv | 179 +++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC generation and a DEPTH-entry {pc, instr, pred_taken}
// fetch queue. One I-mem read outstanding at a time; redirects flush the queue
// and retire any in-flight response without pushing it.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       inst_read,
  output logic [XLEN-1:0]            inst_addr,
  input  logic                       inst_resp,
  input  logic [XLEN-1:0]            inst_rdata,
  output logic [XLEN-1:0]            bp_query_pc,
  input  logic                       bp_taken,
  input  logic [XLEN-1:0]            bp_target,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_instr,
  output logic                       deq_pred_taken,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int unsigned     CW       = $clog2(DEPTH + 1);
  localparam int unsigned     PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_pc_next;
  logic [XLEN-1:0] step_pc;
  logic [XLEN-1:0] redirect_aligned;

  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];
  logic            q_taken [DEPTH];

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;

  logic            push;
  logic            pop;
  logic            issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Queue handshakes, post-push/pop occupancy and candidate PCs.
  always_comb begin
    push             = (state == REQ) && inst_resp && !redirect_valid;
    pop              = (count != '0) && deq_ready && !redirect_valid;
    count_after      = count + CW'(push) - CW'(pop);
    step_pc          = bp_taken ? bp_target : req_pc + XLEN'(4);
    redirect_aligned = redirect_pc & ~XLEN'(3);
  end

  // Next-state logic; redirect outranks everything else.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!redirect_valid && (count < DEPTH_C)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_next = inst_resp ? IDLE : DROP;
        end else if (inst_resp) begin
          state_next = (count_after < DEPTH_C) ? REQ : IDLE;
        end
      end
      DROP: begin
        // A response retires the stale request even if another redirect
        // arrives alongside it; fetch_pc already carries the newest target.
        if (inst_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch/request PC selection.
  always_comb begin
    issue         = (state_next == REQ) && ((state == IDLE) || push);
    fetch_pc_next = fetch_pc;
    req_pc_next   = req_pc;
    if (redirect_valid) begin
      fetch_pc_next = redirect_aligned;
    end else if (push) begin
      fetch_pc_next = step_pc;
    end
    if (issue) begin
      req_pc_next = push ? step_pc : fetch_pc;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_next;
      req_pc   <= req_pc_next;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= count_after;
      if (push) begin
        tail <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= req_pc;
      q_instr[tail] <= inst_rdata;
      q_taken[tail] <= bp_taken;
    end
  end

  // Output decode.
  always_comb begin
    inst_read      = (state != IDLE);
    inst_addr      = req_pc;
    bp_query_pc    = req_pc;
    deq_valid      = (count != '0);
    deq_pc         = q_pc[head];
    deq_instr      = q_instr[head];
    deq_pred_taken = q_taken[head];
    fq_count       = count;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit with a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h4000_0000;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       inst_read;
  logic [XLEN-1:0]            inst_addr;
  logic                       inst_resp = 1'b0;
  logic [XLEN-1:0]            inst_rdata = '0;
  logic [XLEN-1:0]            bp_query_pc;
  logic                       bp_taken = 1'b0;
  logic [XLEN-1:0]            bp_target = '0;
  logic                       redirect_valid = 1'b0;
  logic [XLEN-1:0]            redirect_pc = '0;
  logic                       deq_valid;
  logic                       deq_ready = 1'b0;
  logic [XLEN-1:0]            deq_pc;
  logic [XLEN-1:0]            deq_instr;
  logic                       deq_pred_taken;
  logic [$clog2(DEPTH+1)-1:0] fq_count;

  fetch_queue_unit #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_read     (inst_read),
    .inst_addr     (inst_addr),
    .inst_resp     (inst_resp),
    .inst_rdata    (inst_rdata),
    .bp_query_pc   (bp_query_pc),
    .bp_taken      (bp_taken),
    .bp_target     (bp_target),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_pc        (deq_pc),
    .deq_instr     (deq_instr),
    .deq_pred_taken(deq_pred_taken),
    .fq_count      (fq_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
  } ent_t;

  // Reference model: queue contents, fetch PC, and whether a read is
  // outstanding and whether its response is to be thrown away.
  ent_t        mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_req;
  bit          m_pending;
  bit          m_discard;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch   = RESET_PC;
    m_req     = RESET_PC;
    m_pending = 0;
    m_discard = 0;
  endtask

  // One rising edge of behaviour, computed from the inputs held across it.
  task automatic model_update();
    int   cnt0;
    ent_t e;
    cnt0 = mq.size();
    if (redirect_valid) begin
      mq.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      if (m_pending) begin
        if (inst_resp) begin
          m_pending = 0;
          m_discard = 0;
        end else begin
          m_discard = 1;
        end
      end
    end else begin
      if (deq_ready && cnt0 > 0) void'(mq.pop_front());
      if (m_pending && inst_resp) begin
        if (m_discard) begin
          m_pending = 0;
          m_discard = 0;
        end else begin
          e.pc    = m_req;
          e.instr = inst_rdata;
          e.taken = bp_taken;
          mq.push_back(e);
          m_fetch = bp_taken ? bp_target : m_req + 32'd4;
          if (mq.size() < DEPTH) m_req = m_fetch;
          else m_pending = 0;
        end
      end else if (!m_pending && cnt0 < DEPTH) begin
        m_pending = 1;
        m_req     = m_fetch;
      end
    end
  endtask

  task automatic compare_all();
    chk("fq_count", 32'(fq_count), 32'(mq.size()));
    chk("deq_valid", 32'(deq_valid), 32'(mq.size() != 0));
    chk("inst_read", 32'(inst_read), 32'(m_pending));
    if (m_pending) begin
      chk("inst_addr", inst_addr, m_req);
      chk("bp_query_pc", bp_query_pc, m_req);
    end
    if (mq.size() != 0) begin
      chk("deq_pc", deq_pc, mq[0].pc);
      chk("deq_instr", deq_instr, mq[0].instr);
      chk("deq_pred_taken", 32'(deq_pred_taken), 32'(mq[0].taken));
    end
  endtask

  // Drive inputs just after an edge, let one edge happen, then check.
  // rmode: 0 no response, 1 respond if a read is pending, 2 force a strobe.
  task automatic step(input int rmode, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input bit tk, input logic [31:0] tgt);
    inst_resp      = (rmode == 2) || (rmode == 1 && inst_read);
    inst_rdata     = $urandom;
    deq_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    bp_taken       = tk;
    bp_target      = tgt;
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask

  task automatic apply_reset();
    inst_resp      = 0;
    deq_ready      = 0;
    redirect_valid = 0;
    bp_taken       = 0;
    rst            = 1;
    #1;
    chk("rst_inst_read", 32'(inst_read), 0);
    chk("rst_deq_valid", 32'(deq_valid), 0);
    chk("rst_fq_count", 32'(fq_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  logic [31:0] rpc_r;
  logic [31:0] tgt_r;
  int          rdy_pct;
  int          rm;

  initial begin
    model_reset();
    #2;

    // Sequential fetch into a stalled queue, then one pop re-opens fetch.
    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr_order", inst_addr, 32'h4000_0000 + 32'(4 * k));
      step(1, 0, 0, 0, 0, 0);
    end
    chk("t2_full_count", 32'(fq_count), 4);
    chk("t2_full_no_read", 32'(inst_read), 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t2_stall_no_read", 32'(inst_read), 0);
    chk("t1_head_pc", deq_pc, 32'h4000_0000);
    step(0, 1, 0, 0, 0, 0);
    chk("t2_after_pop", 32'(fq_count), 3);
    for (int k = 0; k < 5 && !inst_read; k++) step(0, 0, 0, 0, 0, 0);
    chk("t2_refetch_read", 32'(inst_read), 1);
    chk("t2_refetch_addr", inst_addr, 32'h4000_0010);

    // Redirect while a read waits: response dropped, refetch aligned target.
    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h4000_0102, 0, 0);
    chk("t3_drop_read", 32'(inst_read), 1);
    chk("t3_drop_addr", inst_addr, 32'h4000_0000);
    step(1, 0, 0, 0, 0, 0);
    chk("t3_dropped_idle", 32'(inst_read), 0);
    chk("t3_dropped_count", 32'(fq_count), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_new_addr", inst_addr, 32'h4000_0100);

    // Redirect coincident with a response, two entries queued.
    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t4_two_queued", 32'(fq_count), 2);
    step(1, 0, 1, 32'h4000_0200, 0, 0);
    chk("t4_flush_count", 32'(fq_count), 0);
    chk("t4_flush_idle", 32'(inst_read), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_next_addr", inst_addr, 32'h4000_0200);

    // Predicted-taken response steers the next fetch.
    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h4000_0800);
    chk("t5_target_addr", inst_addr, 32'h4000_0800);
    step(0, 1, 0, 0, 0, 0);
    chk("t5_head_pc", deq_pc, 32'h4000_0004);
    chk("t5_head_taken", 32'(deq_pred_taken), 1);

    // PC wrap, then asynchronous reset with a read pending.
    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t6_top_addr", inst_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_wrap_addr", inst_addr, 32'h0000_0000);
    chk("t6_wrap_count", 32'(fq_count), 1);
    #2;
    rst = 1;
    #1;
    chk("t6_async_read", 32'(inst_read), 0);
    chk("t6_async_valid", 32'(deq_valid), 0);
    chk("t6_async_count", 32'(fq_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rdy_pct = (n < 1500) ? 25 : 70;
      if ($urandom_range(0, 99) < 40) rm = 1;
      else if ($urandom_range(0, 99) < 4) rm = 2;
      else rm = 0;
      case ($urandom_range(0, 3))
        0: rpc_r = 32'h4000_0000 + 32'($urandom_range(0, 1023));
        1: rpc_r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2: rpc_r = $urandom;
        default: rpc_r = 32'h4000_0100;
      endcase
      tgt_r = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                         : 32'h4000_0000 + 32'(4 * $urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
      end else begin
        step(rm, $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 6,
             rpc_r, $urandom_range(0, 99) < 20, tgt_r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
